// File: rtl/aes_reseed_scheduler.sv
// aes_reseed_scheduler
// Gates the user plaintext/key stream into the masked AES top and forces a
// PRNG reseed after RESEED_PERIOD accepted encryptions or on request. Before
// a seed is offered, every in-flight encryption is drained. The core then
// sees no in_valid and is idle when the seed is presented.
//
// RESEED_PERIOD must lie in 1 .. 2**CNT_W-1.
module aes_reseed_scheduler #(
  parameter int RESEED_PERIOD = 1024,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             usr_in_valid,
  output logic             usr_in_ready,
  output logic             core_in_valid,
  input  logic             core_in_ready,
  input  logic             core_out_valid,
  input  logic             core_out_ready,
  input  logic             src_seed_valid,
  output logic             src_seed_ready,
  input  logic [79:0]      src_seed,
  output logic             core_seed_valid,
  input  logic             core_seed_ready,
  output logic [79:0]      core_seed,
  input  logic             force_reseed,
  output logic [CNT_W-1:0] enc_count,
  output logic             seeded
);

  typedef enum logic [1:0] {
    SEED  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Period compared one bit wider so that count+1 can never alias to zero.
  localparam logic [CNT_W:0]   PERIOD  = (CNT_W+1)'(RESEED_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] enc_cnt;
  logic [CNT_W-1:0] enc_cnt_nxt;
  logic [1:0]       inflight;
  logic [1:0]       inflight_nxt;
  logic             force_pend;
  logic             force_pend_nxt;

  logic             in_hs;
  logic             out_hs;
  logic             seed_hs;
  logic [CNT_W:0]   cnt_plus;

  // Saturating increment of the encryption counter; it never wraps.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] cur);
    if (cur == CNT_MAX) begin
      return cur;
    end
    return cur + CNT_W'(1);
  endfunction

  // In-flight tracker: +1 on input handshake, -1 on output handshake,
  // unchanged when both happen; clamps at 3 and at 0.
  function automatic logic [1:0] inflight_update(input logic [1:0] cur,
                                                 input logic       up,
                                                 input logic       dn);
    logic [1:0] res;
    res = cur;
    case ({up, dn})
      2'b10:   res = (cur == 2'd3) ? cur : cur + 2'd1;
      2'b01:   res = (cur == 2'd0) ? cur : cur - 2'd1;
      default: res = cur;
    endcase
    return res;
  endfunction

  // Handshake detection from state and raw inputs (independent of output gating).
  always_comb begin
    in_hs    = (state == RUN) & usr_in_valid & core_in_ready;
    seed_hs  = (state == SEED) & src_seed_valid & core_seed_ready;
    out_hs   = core_out_valid & core_out_ready;
    cnt_plus = {1'b0, enc_cnt} + (CNT_W+1)'(in_hs);
  end

  // Next-state, counter and pending-request logic.
  always_comb begin
    state_nxt      = state;
    enc_cnt_nxt    = enc_cnt;
    force_pend_nxt = force_pend;
    inflight_nxt   = inflight_update(inflight, in_hs, out_hs);
    case (state)
      SEED: begin
        if (force_reseed) begin
          force_pend_nxt = 1'b1;
        end
        // The seed being consumed now satisfies any outstanding request.
        if (seed_hs) begin
          state_nxt      = RUN;
          enc_cnt_nxt    = '0;
          force_pend_nxt = 1'b0;
        end
      end
      RUN: begin
        if (in_hs) begin
          enc_cnt_nxt = sat_inc_cnt(enc_cnt);
        end
        // A handshake coinciding with force_reseed is still counted.
        if ((cnt_plus == PERIOD) || force_pend || force_reseed) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (force_reseed) begin
          force_pend_nxt = 1'b1;
        end
        if (inflight == 2'd0) begin
          state_nxt = SEED;
        end
      end
      default: begin
        state_nxt = SEED;
      end
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEED;
      enc_cnt    <= '0;
      inflight   <= 2'd0;
      force_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      enc_cnt    <= enc_cnt_nxt;
      inflight   <= inflight_nxt;
      force_pend <= force_pend_nxt;
    end
  end

  // Output steering; every output, combinational ones included, is held at 0 during reset.
  always_comb begin
    usr_in_ready    = 1'b0;
    core_in_valid   = 1'b0;
    src_seed_ready  = 1'b0;
    core_seed_valid = 1'b0;
    core_seed       = src_seed;
    enc_count       = enc_cnt;
    seeded          = (state == RUN);
    case (state)
      SEED: begin
        core_seed_valid = src_seed_valid;
        src_seed_ready  = core_seed_ready;
      end
      RUN: begin
        core_in_valid = usr_in_valid;
        usr_in_ready  = core_in_ready;
      end
      default: begin
      end
    endcase
    if (rst) begin
      usr_in_ready    = 1'b0;
      core_in_valid   = 1'b0;
      src_seed_ready  = 1'b0;
      core_seed_valid = 1'b0;
      core_seed       = '0;
      enc_count       = '0;
      seeded          = 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_reseed_scheduler.sv
// Bench for aes_reseed_scheduler with RESEED_PERIOD=3. Stimulus pushes the
// expected output snapshot (and any seed expected to be consumed) into
// queues; a monitor on the falling edge pops and compares.
module tb_aes_reseed_scheduler;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             usr_in_valid;
  logic             usr_in_ready;
  logic             core_in_valid;
  logic             core_in_ready;
  logic             core_out_valid;
  logic             core_out_ready;
  logic             src_seed_valid;
  logic             src_seed_ready;
  logic [79:0]      src_seed;
  logic             core_seed_valid;
  logic             core_seed_ready;
  logic [79:0]      core_seed;
  logic             force_reseed;
  logic [CNT_W-1:0] enc_count;
  logic             seeded;

  aes_reseed_scheduler #(.RESEED_PERIOD(3), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .usr_in_valid    (usr_in_valid),
    .usr_in_ready    (usr_in_ready),
    .core_in_valid   (core_in_valid),
    .core_in_ready   (core_in_ready),
    .core_out_valid  (core_out_valid),
    .core_out_ready  (core_out_ready),
    .src_seed_valid  (src_seed_valid),
    .src_seed_ready  (src_seed_ready),
    .src_seed        (src_seed),
    .core_seed_valid (core_seed_valid),
    .core_seed_ready (core_seed_ready),
    .core_seed       (core_seed),
    .force_reseed    (force_reseed),
    .enc_count       (enc_count),
    .seeded          (seeded)
  );

  typedef struct {
    string       name;
    logic [20:0] ctl;   // {usr_in_ready, core_in_valid, src_seed_ready, core_seed_valid, seeded, enc_count}
    logic [79:0] seed;
  } snap_t;

  snap_t       exp_q[$];
  logic [79:0] seed_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  localparam logic [79:0] S1 = 80'h0123_4567_89AB_CDEF_0011;
  localparam logic [79:0] S2 = 80'hFEDC_BA98_7654_3210_A5A5;
  localparam logic [79:0] S3 = 80'h1357_9BDF_2468_ACE0_5A5A;
  localparam logic [79:0] S4 = 80'hC0FF_EE00_DEAD_BEEF_1234;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic uir, input logic civ,
                            input logic ssr, input logic csv, input logic sd,
                            input logic [15:0] cnt, input logic [79:0] sv);
    snap_t s;
    s.name = nm;
    s.ctl  = {uir, civ, ssr, csv, sd, cnt};
    s.seed = sv;
    exp_q.push_back(s);
  endtask

  // Monitor: compares snapshots and every consumed seed on the falling edge.
  always @(negedge clk) begin
    snap_t       e;
    logic [20:0] act;
    logic [79:0] es;
    act = {usr_in_ready, core_in_valid, src_seed_ready, core_seed_valid, seeded, enc_count};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act !== e.ctl || core_seed !== e.seed) begin
        n_fail++;
        $display("FAIL %s: got ctl=%h seed=%h, expected ctl=%h seed=%h",
                 e.name, act, core_seed, e.ctl, e.seed);
      end
    end
    if (core_seed_valid === 1'b1 && core_seed_ready === 1'b1) begin
      n_checks++;
      if (seed_q.size() == 0) begin
        n_fail++;
        $display("FAIL seed_unexpected: got seed=%h, expected no seed handshake", core_seed);
      end else begin
        es = seed_q.pop_front();
        if (core_seed !== es) begin
          n_fail++;
          $display("FAIL seed_value: got %h, expected %h", core_seed, es);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; usr_in_valid = 1'b1; core_in_ready = 1'b1;
    core_out_valid = 1'b1; core_out_ready = 1'b1;
    src_seed_valid = 1'b1; src_seed = S1; core_seed_ready = 1'b1; force_reseed = 1'b1;
    cyc(); cyc();
    expect_out("reset_outs", 0, 0, 0, 0, 0, 16'd0, 80'd0);

    // Initial seeding
    cyc(); rst = 1'b0; core_seed_ready = 1'b0; core_out_valid = 1'b0;
    core_out_ready = 1'b0; force_reseed = 1'b0;
    expect_out("seed_wait", 0, 0, 0, 1, 0, 16'd0, S1);
    cyc(); core_seed_ready = 1'b1; seed_q.push_back(S1);
    expect_out("seed_take", 0, 0, 1, 1, 0, 16'd0, S1);
    cyc(); usr_in_valid = 1'b0;
    expect_out("run_seed_blocked", 1, 0, 0, 0, 1, 16'd0, S1);

    // Period-driven reseed after 3 encryptions
    cyc(); core_seed_ready = 1'b0; usr_in_valid = 1'b1;
    expect_out("hs1", 1, 1, 0, 0, 1, 16'd0, S1);
    cyc(); expect_out("hs2", 1, 1, 0, 0, 1, 16'd1, S1);
    cyc(); expect_out("hs3", 1, 1, 0, 0, 1, 16'd2, S1);
    cyc(); core_out_valid = 1'b1; core_out_ready = 1'b1;
    expect_out("drain_a", 0, 0, 0, 0, 0, 16'd3, S1);
    cyc(); expect_out("drain_b", 0, 0, 0, 0, 0, 16'd3, S1);
    cyc(); expect_out("drain_c", 0, 0, 0, 0, 0, 16'd3, S1);
    cyc(); core_out_valid = 1'b0;
    expect_out("drain_empty", 0, 0, 0, 0, 0, 16'd3, S1);

    // force_reseed while in SEED: one reseed, then RUN stays RUN
    cyc(); src_seed = S2; force_reseed = 1'b1;
    expect_out("seed2_wait", 0, 0, 0, 1, 0, 16'd3, S2);
    cyc(); force_reseed = 1'b0; core_seed_ready = 1'b1; seed_q.push_back(S2);
    expect_out("seed2_take", 0, 0, 1, 1, 0, 16'd3, S2);
    cyc(); core_seed_ready = 1'b0; usr_in_valid = 1'b0;
    expect_out("run2_a", 1, 0, 0, 0, 1, 16'd0, S2);
    cyc(); expect_out("run2_no_pend", 1, 0, 0, 0, 1, 16'd0, S2);

    // force_reseed with the 2nd handshake
    cyc(); usr_in_valid = 1'b1;
    expect_out("f_hs1", 1, 1, 0, 0, 1, 16'd0, S2);
    cyc(); force_reseed = 1'b1;
    expect_out("f_hs2", 1, 1, 0, 0, 1, 16'd1, S2);
    cyc(); force_reseed = 1'b0; core_out_valid = 1'b1; core_out_ready = 1'b0;
    expect_out("f_drain_a", 0, 0, 0, 0, 0, 16'd2, S2);
    cyc(); core_out_ready = 1'b1;
    expect_out("f_drain_b", 0, 0, 0, 0, 0, 16'd2, S2);
    cyc(); expect_out("f_drain_c", 0, 0, 0, 0, 0, 16'd2, S2);
    cyc(); core_out_valid = 1'b0;
    expect_out("f_drain_d", 0, 0, 0, 0, 0, 16'd2, S2);
    cyc(); src_seed = S3;
    expect_out("seed3_wait", 0, 0, 0, 1, 0, 16'd2, S3);
    cyc(); core_seed_ready = 1'b1; seed_q.push_back(S3);
    expect_out("seed3_take", 0, 0, 1, 1, 0, 16'd2, S3);

    // Reset while draining with one encryption in flight
    cyc(); core_seed_ready = 1'b0; force_reseed = 1'b1;
    expect_out("r_hs", 1, 1, 0, 0, 1, 16'd0, S3);
    cyc(); force_reseed = 1'b0; usr_in_valid = 1'b0;
    expect_out("r_drain", 0, 0, 0, 0, 0, 16'd1, S3);
    cyc(); rst = 1'b1; usr_in_valid = 1'b1; core_seed_ready = 1'b1;
    expect_out("rst_mid", 0, 0, 0, 0, 0, 16'd0, 80'd0);
    cyc(); rst = 1'b0; core_seed_ready = 1'b0;
    expect_out("rst_seed", 0, 0, 0, 1, 0, 16'd0, S3);
    cyc(); core_seed_ready = 1'b1; src_seed = S4; seed_q.push_back(S4);
    expect_out("seed4_take", 0, 0, 1, 1, 0, 16'd0, S4);
    cyc(); core_seed_ready = 1'b0; usr_in_valid = 1'b0;
    expect_out("run4", 1, 0, 0, 0, 1, 16'd0, S4);
    cyc(); expect_out("run4_hold", 1, 0, 0, 0, 1, 16'd0, S4);

    cyc(); cyc();
    n_checks++;
    if (exp_q.size() != 0 || seed_q.size() != 0) begin
      n_fail++;
      $display("FAIL queues_drained: got %0d snapshots and %0d seeds left, expected 0 and 0",
               exp_q.size(), seed_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
